matmul_controller: RTL and testbench

MATMUL_CONTROLLER -- requirements
Module: matmul_controller

---
 rtl/matmul_controller.sv | 138 +++++++++++++
 tb/tb_matmul_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_controller.sv
// Streaming NxN signed matrix multiplier controller.
// Loads A then B, computes C = A*B with one shared MAC, streams C row-major.
module matmul_controller #(
  parameter int DATA_WIDTH = 3,
  parameter int N          = 2,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+$clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  output logic [ACC_WIDTH-1:0]    out_data,
  output logic [$clog2(N)-1:0]    out_row,
  output logic [$clog2(N)-1:0]    out_col,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int IW = $clog2(N);
  localparam int AW = $clog2(N*N);
  localparam int PW = $clog2(2*N*N);
  localparam int MW = 2*DATA_WIDTH;
  localparam logic [PW-1:0] P_LAST = PW'(2*N*N-1);
  localparam logic [IW-1:0] I_LAST = IW'(N-1);

  typedef enum logic [1:0] {
    LOAD,
    MAC,
    OUT
  } state_t;

  state_t state;

  logic [DATA_WIDTH-1:0] a_mem [N*N];
  logic [DATA_WIDTH-1:0] b_mem [N*N];

  logic [PW-1:0] p;
  logic [IW-1:0] i;
  logic [IW-1:0] j;
  logic [IW-1:0] k;

  logic signed [ACC_WIDTH-1:0]  acc;
  logic [AW-1:0]                a_idx;
  logic [AW-1:0]                b_idx;
  logic [AW-1:0]                ld_idx;
  logic                         ld_to_a;
  logic signed [DATA_WIDTH-1:0] a_op;
  logic signed [DATA_WIDTH-1:0] b_op;
  logic signed [MW-1:0]         prod;
  logic signed [ACC_WIDTH-1:0]  prod_x;

  // Operand addressing, load addressing and the shared signed multiplier
  always_comb begin
    a_idx   = AW'(int'(i) * N + int'(k));
    b_idx   = AW'(int'(k) * N + int'(j));
    ld_to_a = int'(p) < N*N;
    ld_idx  = ld_to_a ? AW'(p) : AW'(int'(p) - N*N);
    a_op    = a_mem[a_idx];
    b_op    = b_mem[b_idx];
    prod    = a_op * b_op;
    prod_x  = {{(ACC_WIDTH-MW){prod[MW-1]}}, prod};
  end

  // Control FSM: load stream, one MAC per cycle, present each result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
      p     <= '0;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      acc   <= '0;
      done  <= 1'b0;
      for (int n = 0; n < N*N; n++) begin
        a_mem[n] <= '0;
        b_mem[n] <= '0;
      end
    end else begin
      done <= 1'b0;
      unique case (state)
        LOAD: begin
          if (in_valid) begin
            if (ld_to_a) a_mem[ld_idx] <= in_data;
            else         b_mem[ld_idx] <= in_data;
            if (p == P_LAST) begin
              p     <= '0;
              i     <= '0;
              j     <= '0;
              k     <= '0;
              state <= MAC;
            end else begin
              p <= p + PW'(1);
            end
          end
        end
        MAC: begin
          acc <= (k == '0) ? prod_x : acc + prod_x;
          if (k == I_LAST) state <= OUT;
          else             k     <= k + IW'(1);
        end
        OUT: begin
          if (out_ready) begin
            k <= '0;
            if (i == I_LAST && j == I_LAST) begin
              i     <= '0;
              j     <= '0;
              done  <= 1'b1;
              state <= LOAD;
            end else begin
              state <= MAC;
              if (j == I_LAST) begin
                j <= '0;
                i <= i + IW'(1);
              end else begin
                j <= j + IW'(1);
              end
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Outputs decode straight from registered state
  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == OUT);
    busy      = (state != LOAD);
    out_data  = acc;
    out_row   = i;
    out_col   = j;
  end

endmodule

// File: tb/tb_matmul_controller.sv
// Bench for matmul_controller (DATA_WIDTH=3, N=2).
// Random jobs, reference matrix product, queued scoreboard.
module tb_matmul_controller;

  localparam int DW = 3;
  localparam int N  = 2;
  localparam int AC = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [AC-1:0] out_data;
  logic          out_row;
  logic          out_col;
  logic          out_ready;
  logic          busy;
  logic          done;

  matmul_controller #(.DATA_WIDTH(DW), .N(N), .ACC_WIDTH(AC)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            row;
    int            col;
    logic [AC-1:0] data;
  } exp_t;

  exp_t sbq[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int exp_done = 0;
  int done_cnt = 0;
  int elems[8];
  bit aborted;

  logic          stall_pend = 1'b0;
  logic [AC+1:0] stall_val;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference: plain matrix product over the loaded element list
  task automatic push_expected();
    exp_t x;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        int s = 0;
        for (int m = 0; m < N; m++)
          s += elems[r*N+m] * elems[N*N+m*N+c];
        x.row  = r;
        x.col  = c;
        x.data = AC'(s);
        sbq.push_back(x);
      end
  endtask

  // Monitor: compare every accepted result, and hold-stability on stalls
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (stall_pend) begin
        checks++;
        if ({out_data, out_row, out_col} != stall_val) begin
          errors++;
          $display("FAIL hold: got %h expected %h",
                   {out_data, out_row, out_col}, stall_val);
        end
      end
      if (out_ready) begin
        stall_pend = 1'b0;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got (%0d,%0d)=%0d expected none",
                   out_row, out_col, out_data);
        end else begin
          e = sbq.pop_front();
          if (int'(out_row) != e.row || int'(out_col) != e.col ||
              out_data != e.data) begin
            errors++;
            $display("FAIL result: got (%0d,%0d)=%h expected (%0d,%0d)=%h",
                     out_row, out_col, out_data, e.row, e.col, e.data);
          end
        end
      end else begin
        stall_pend = 1'b1;
        stall_val  = {out_data, out_row, out_col};
      end
    end else begin
      stall_pend = 1'b0;
    end
    if (!rst && done) done_cnt++;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_out_data"},  int'(out_data), 0);
    chk({tag, "_out_row"},   int'(out_row), 0);
    chk({tag, "_out_col"},   int'(out_col), 0);
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check_reset(tag);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    sbq.delete();
    stall_pend = 1'b0;
  endtask

  task automatic load_job(input bit gaps, input int rst_at);
    int p = 0;
    int guard = 0;
    while (p < 8 && guard < 200) begin
      guard++;
      in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_data  = in_valid ? DW'(elems[p]) : DW'($urandom_range(0, 7));
      if (p == rst_at && in_valid) begin
        pulse_reset("rst_load");
        aborted = 1'b1;
        return;
      end
      if (in_valid && in_ready) p++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (p < 8) chk("load_timeout", p, 8);
  endtask

  // rmode: 0 always ready, 1 random ready, 2 five-cycle stall on (0,1)
  task automatic run_job(input bit gaps, input bit garbage, input int rmode,
                         input int rst_load, input bit rst_out);
    int lat = 0;
    int stall = 0;
    int guard = 0;
    bit first = 1'b1;
    bit fin = 1'b0;
    bit last;
    aborted = 1'b0;
    load_job(gaps, rst_load);
    if (aborted) return;
    push_expected();
    exp_done++;
    while (!fin && guard < 200) begin
      guard++;
      last = out_valid && out_row && out_col;
      if (rst_out && out_valid && out_row && !out_col) begin
        out_ready = 1'b0;
        pulse_reset("rst_out");
        exp_done--;
        return;
      end
      case (rmode)
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (out_valid && !out_row && out_col && stall < 5) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b1;
      endcase
      in_valid = garbage && !(last && out_ready);
      in_data  = DW'($urandom_range(0, 7));
      if (rmode == 2 && !out_ready) chk("stall_busy", int'(busy), 1);
      @(posedge clk); #1;
      lat++;
      if (first && out_valid) begin
        first = 1'b0;
        chk("first_latency", lat, N);
      end
      if (done) fin = 1'b1;
    end
    in_valid = 1'b0;
    if (!fin) chk("job_timeout", 0, 1);
  endtask

  task automatic rand_elems();
    for (int n = 0; n < 8; n++) elems[n] = int'($urandom_range(0, 7)) - 4;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;
    #1;
    chk("por_in_ready", int'(in_ready), 1);
    @(posedge clk); #1;

    elems = '{1, 2, 3, -1, 2, -4, 1, 3};
    run_job(1'b0, 1'b0, 0, -1, 1'b0);

    elems = '{-4, -4, -4, -4, -4, -4, -4, -4};
    run_job(1'b0, 1'b0, 0, -1, 1'b0);

    elems = '{1, 2, 3, -1, 2, -4, 1, 3};
    run_job(1'b0, 1'b0, 2, -1, 1'b0);

    for (int t = 0; t < 3; t++) begin
      rand_elems();
      run_job(1'b1, 1'b1, 1, -1, 1'b0);
    end

    rand_elems();
    run_job(1'b0, 1'b0, 0, 4, 1'b0);
    run_job(1'b0, 1'b0, 0, -1, 1'b0);

    elems = '{1, 2, 3, -1, 2, -4, 1, 3};
    run_job(1'b0, 1'b0, 0, -1, 1'b1);
    rand_elems();
    run_job(1'b0, 1'b0, 0, -1, 1'b0);

    rand_elems();
    run_job(1'b0, 1'b0, 0, -1, 1'b0);
    rand_elems();
    run_job(1'b0, 1'b0, 0, -1, 1'b0);

    for (int t = 0; t < 8; t++) begin
      rand_elems();
      run_job(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 1)), -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    chk("done_count", done_cnt, exp_done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
